// File: rtl/hex_cmd_collector.sv
// rtl/hex_cmd_collector.sv - gathers ASCII hex chars into a word, hands it off on CR/LF (timeout build: HEX_COLLECT_TIMEOUT_EN)
module hex_cmd_collector #(
    parameter int CHAR_NUM    = 2,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            iRX_DATA,
    input  logic                  iRX_VALID,
    output logic [CHAR_NUM*4-1:0] oDATA,
    output logic                  oVALID,
    input  logic                  iREADY,
    output logic                  oERR,
    output logic                  oBUSY
);

    localparam int W     = CHAR_NUM * 4;
    localparam int CNT_W = $clog2(CHAR_NUM + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    state_t           state_q, state_n;
    logic [W-1:0]     buf_q, buf_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             err_q, err_n;

    logic             is_hex;
    logic             is_term;
    logic [3:0]       nib;
    logic             tmo_hit;

    // A width of zero characters makes no sense; the timeout must be at least one cycle
    if (CHAR_NUM < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("hex_cmd_collector: CHAR_NUM and TIMEOUT_CYC must be >= 1");
    end

    // Classify the incoming byte and extract its nibble value
    always_comb begin
        is_hex  = 1'b0;
        is_term = 1'b0;
        nib     = 4'h0;
        if (iRX_DATA >= 8'h30 && iRX_DATA <= 8'h39) begin
            is_hex = 1'b1;
            nib    = 4'(iRX_DATA - 8'h30);
        end else if (iRX_DATA >= 8'h41 && iRX_DATA <= 8'h46) begin
            is_hex = 1'b1;
            nib    = 4'(iRX_DATA - 8'h37);
        end else if (iRX_DATA >= 8'h61 && iRX_DATA <= 8'h66) begin
            is_hex = 1'b1;
            nib    = 4'(iRX_DATA - 8'h57);
        end else if (iRX_DATA == 8'h0D || iRX_DATA == 8'h0A) begin
            is_term = 1'b1;
        end
    end

`ifdef HEX_COLLECT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_q;

    // Idle-cycle counter: any received byte restarts it, only COLLECT/FLUSH let it run
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tmo_q <= '0;
        end else if (iRX_VALID || tmo_hit || !(state_q == COLLECT || state_q == FLUSH)) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    // The TIMEOUT_CYC-th consecutive idle cycle abandons the partial word
    assign tmo_hit = (state_q == COLLECT || state_q == FLUSH) && !iRX_VALID &&
                     (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // State, word buffer, char count and error pulse registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            buf_q   <= buf_n;
            cnt_q   <= cnt_n;
            err_q   <= err_n;
        end
    end

    // Next-state logic: byte handling per state, then the timeout override
    always_comb begin
        state_n = state_q;
        buf_n   = buf_q;
        cnt_n   = cnt_q;
        err_n   = 1'b0;
        case (state_q)
            IDLE: begin
                if (iRX_VALID) begin
                    if (is_hex) begin
                        buf_n      = '0;
                        buf_n[3:0] = nib;
                        cnt_n      = CNT_W'(1);
                        state_n    = COLLECT;
                    end else if (!is_term) begin
                        err_n   = 1'b1;
                        state_n = FLUSH;
                    end
                end
            end
            COLLECT: begin
                if (iRX_VALID) begin
                    if (is_hex) begin
                        if (cnt_q == CNT_W'(CHAR_NUM)) begin
                            err_n   = 1'b1;
                            state_n = FLUSH;
                        end else begin
                            // Shifting left keeps the first char in the MS nibble;
                            // short words end up zero-extended automatically
                            buf_n      = buf_q << 4;
                            buf_n[3:0] = nib;
                            cnt_n      = cnt_q + 1'b1;
                        end
                    end else if (is_term) begin
                        state_n = HOLD;
                    end else begin
                        err_n   = 1'b1;
                        state_n = FLUSH;
                    end
                end
            end
            HOLD: begin
                // Bytes arriving while a word is pending are lost, the word is not
                if (iRX_VALID) begin
                    err_n = 1'b1;
                end
                if (iREADY) begin
                    buf_n   = '0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            FLUSH: begin
                if (iRX_VALID && is_term) begin
                    buf_n   = '0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                buf_n   = '0;
                cnt_n   = '0;
            end
        endcase

        if (tmo_hit) begin
            err_n   = (state_q == COLLECT);
            buf_n   = '0;
            cnt_n   = '0;
            state_n = IDLE;
        end
    end

    assign oDATA  = buf_q;
    assign oVALID = (state_q == HOLD);
    assign oERR   = err_q;
    assign oBUSY  = (state_q != IDLE);

endmodule

// File: tb/tb_hex_cmd_collector.sv
// tb/tb_hex_cmd_collector.sv - directed self-checking bench for hex_cmd_collector
module tb_hex_cmd_collector;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] iRX_DATA = 8'h00;
    logic       iRX_VALID = 1'b0;
    logic [7:0] oDATA;
    logic       oVALID;
    logic       iREADY = 1'b0;
    logic       oERR;
    logic       oBUSY;

    int vectors = 0;
    int miscompares = 0;

    hex_cmd_collector #(
        .CHAR_NUM    (2),
        .TIMEOUT_CYC (16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .iRX_DATA  (iRX_DATA),
        .iRX_VALID (iRX_VALID),
        .oDATA     (oDATA),
        .oVALID    (oVALID),
        .iREADY    (iREADY),
        .oERR      (oERR),
        .oBUSY     (oBUSY)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        iRX_DATA  = b;
        iRX_VALID = 1'b1;
        tick();
        iRX_VALID = 1'b0;
    endtask

    task automatic accept();
        iREADY = 1'b1;
        tick();
        iREADY = 1'b0;
    endtask

    initial begin
        int errs;
        int waited;

        // Reset values
        #2;
        check("rst_data", 32'(oDATA), 32'h00);
        check("rst_valid", 32'(oVALID), 32'h0);
        check("rst_err", 32'(oERR), 32'h0);
        check("rst_busy", 32'(oBUSY), 32'h0);
        tick();
        RST = 1'b0;
        tick();

        // 1) "3","f",CR -> 3F
        send("3");
        check("t1_busy", 32'(oBUSY), 32'h1);
        send("f");
        check("t1_novalid", 32'(oVALID), 32'h0);
        send(8'h0D);
        check("t1_valid", 32'(oVALID), 32'h1);
        check("t1_data", 32'(oDATA), 32'h3F);
        accept();
        check("t1_drop", 32'(oVALID), 32'h0);
        check("t1_idle", 32'(oBUSY), 32'h0);

        // 2) "7",LF -> 07; lone CR ignored
        send("7");
        send(8'h0A);
        check("t2_valid", 32'(oVALID), 32'h1);
        check("t2_data", 32'(oDATA), 32'h07);
        accept();
        send(8'h0D);
        check("t2_cr_valid", 32'(oVALID), 32'h0);
        check("t2_cr_err", 32'(oERR), 32'h0);
        check("t2_cr_busy", 32'(oBUSY), 32'h0);

        // 3) overlength "1","2","3" then recovery "A","B",CR
        send("1");
        send("2");
        check("t3_no_err_2", 32'(oERR), 32'h0);
        send("3");
        check("t3_err", 32'(oERR), 32'h1);
        check("t3_flush", 32'(oBUSY), 32'h1);
        tick();
        check("t3_err_1cyc", 32'(oERR), 32'h0);
        send(8'h0D);
        check("t3_noword", 32'(oVALID), 32'h0);
        check("t3_idle", 32'(oBUSY), 32'h0);
        send("A");
        send("B");
        send(8'h0D);
        check("t3_data", 32'(oDATA), 32'hAB);
        check("t3_valid", 32'(oVALID), 32'h1);
        accept();

        // 4) invalid "G" -> flush; "5",CR discarded; then "5",CR -> 05
        send("G");
        check("t4_err", 32'(oERR), 32'h1);
        send("5");
        check("t4_flush_err", 32'(oERR), 32'h0);
        send(8'h0D);
        check("t4_noword", 32'(oVALID), 32'h0);
        send("5");
        send(8'h0D);
        check("t4_valid", 32'(oVALID), 32'h1);
        check("t4_data", 32'(oDATA), 32'h05);
        accept();

        // 5) "C","D",CR held with iREADY=0 while "9" overruns
        send("C");
        send("D");
        send(8'h0D);
        check("t5_data", 32'(oDATA), 32'hCD);
        tick();
        tick();
        send("9");
        check("t5_ovr_err", 32'(oERR), 32'h1);
        check("t5_ovr_valid", 32'(oVALID), 32'h1);
        errs = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (oERR) errs++;
        end
        check("t5_err_once", 32'(errs), 32'h0);
        check("t5_hold_data", 32'(oDATA), 32'hCD);
        accept();
        check("t5_accepted", 32'(oVALID), 32'h0);
        check("t5_clear", 32'(oDATA), 32'h00);

        // Overrun in the handshake cycle; next word starts right after
        send("a");
        send("0");
        send(8'h0A);
        check("t5b_data", 32'(oDATA), 32'hA0);
        iREADY = 1'b1;
        send("1");
        iREADY = 1'b0;
        check("t5b_err", 32'(oERR), 32'h1);
        check("t5b_accepted", 32'(oVALID), 32'h0);
        send("2");
        send(8'h0D);
        check("t5b_next", 32'(oDATA), 32'h02);
        accept();

        // 6) async reset mid-word
        send("4");
        #2;
        RST = 1'b1;
        #1;
        check("t6_rst_busy", 32'(oBUSY), 32'h0);
        check("t6_rst_data", 32'(oDATA), 32'h00);
        tick();
        RST = 1'b0;
        tick();
        check("t6_post_valid", 32'(oVALID), 32'h0);
        check("t6_post_err", 32'(oERR), 32'h0);
        send("E");
        send(8'h0D);
        check("t6_data", 32'(oDATA), 32'h0E);
        accept();

`ifdef HEX_COLLECT_TIMEOUT_EN
        // Timeout: "4" then 16 idle cycles -> oERR, IDLE
        send("4");
        waited = 0;
        while (!oERR && waited < 40) begin
            tick();
            waited++;
        end
        check("t6_tmo_cycles", 32'(waited), 32'd16);
        check("t6_tmo_idle", 32'(oBUSY), 32'h0);
        send("E");
        send(8'h0D);
        check("t6_tmo_data", 32'(oDATA), 32'h0E);
        accept();
`else
        // Without the timeout a partial word waits indefinitely
        send("4");
        waited = 0;
        while (!oERR && waited < 40) begin
            tick();
            waited++;
        end
        check("t6_notmo_busy", 32'(oBUSY), 32'h1);
        check("t6_notmo_err", 32'(waited), 32'd40);
        send(8'h0D);
        check("t6_notmo_data", 32'(oDATA), 32'h04);
        accept();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
